// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file write-back path.
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // One queued write-back: destination register and the value to write.
    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [RF_DATA_WIDTH-1:0] data;
    } rf_wb_entry_t;

    // Register 0 is hard-wired; writes to it are dropped.
    function automatic logic rf_is_x0(input logic [RF_ADDR_WIDTH-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Write-back queue: DEPTH entries of {rd, data} with wrapping pointers.
// The occupancy register breaks the full/empty pointer tie. Per-entry valid
// bits and rd values are exported so the parent can build a hazard scoreboard.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  logic [RF_ADDR_WIDTH-1:0]         push_rd_i,
    input  logic [RF_DATA_WIDTH-1:0]         push_data_i,
    input  logic                             pop_i,
    output logic [RF_ADDR_WIDTH-1:0]         head_rd_o,
    output logic [RF_DATA_WIDTH-1:0]         head_data_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [DEPTH-1:0]                 ent_vld_o,
    output logic [DEPTH*RF_ADDR_WIDTH-1:0]   ent_rd_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    rf_wb_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push, do_pop;
    rf_wb_entry_t     push_entry;

    assign full_o   = (occ_q == OCC_FULL);
    assign empty_o  = (occ_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;

    assign push_entry.rd   = push_rd_i;
    assign push_entry.data = push_data_i;

    assign head_rd_o   = mem_q[rd_ptr_q].rd;
    assign head_data_o = mem_q[rd_ptr_q].data;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state: pointers and occupancy, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage; contents are only meaningful while marked valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    // An entry is live when its distance from the read pointer is below occupancy.
    always_comb begin
        logic [PTR_W-1:0] offs;
        ent_vld_o = '0;
        ent_rd_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - rd_ptr_q;
            ent_vld_o[i] = (OCC_W'(offs) < occ_q);
            ent_rd_o[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port controller. Arbitrates ALU and LSU results (LSU
// first), drops writes to x0, queues the rest and retires one write per cycle
// through registered w_* outputs. Also reports in-flight writes to decode.
module rf_write_ctrl
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [ADDR_WIDTH-1:0] i_alu_rd,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
    input  logic [DATA_WIDTH-1:0] i_lsu_data,
    output logic                  o_w_enable,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [DATA_WIDTH-1:0] o_w_data,
    input  logic [ADDR_WIDTH-1:0] i_chk_addrA,
    input  logic [ADDR_WIDTH-1:0] i_chk_addrB,
    output logic                  o_pendA,
    output logic                  o_pendB,
    output logic                  o_idle,
    output logic [CNT_WIDTH-1:0]  o_wr_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                           q_full, q_empty;
    logic [DEPTH-1:0]               ent_vld;
    logic [DEPTH*RF_ADDR_WIDTH-1:0] ent_rd;
    logic [RF_ADDR_WIDTH-1:0]       head_rd;
    logic [RF_DATA_WIDTH-1:0]       head_data;

    logic                  lsu_acc, alu_acc, push, pop;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // Holding this high freezes draining; it exists only so a bench can fill
    // the queue. In normal operation it is tied low.
    logic drain_hold;
    assign drain_hold = 1'b0;

    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pend_a, pend_b;

    // Readiness looks at the pre-edge count only, so a full queue never passes through.
    assign o_lsu_ready = !q_full;
    assign o_alu_ready = !q_full && !i_lsu_valid;

    // Pick the accepted producer and suppress x0 writes after the handshake.
    always_comb begin
        lsu_acc  = i_lsu_valid && o_lsu_ready;
        alu_acc  = i_alu_valid && o_alu_ready;
        sel_rd   = lsu_acc ? i_lsu_rd : i_alu_rd;
        sel_data = lsu_acc ? i_lsu_data : i_alu_data;
        push     = (lsu_acc || alu_acc) && !rf_is_x0(sel_rd);
        pop      = !q_empty && !drain_hold;
    end

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .push_i      (push),
        .push_rd_i   (sel_rd),
        .push_data_i (sel_data),
        .pop_i       (pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .ent_vld_o   (ent_vld),
        .ent_rd_o    (ent_rd)
    );

    // Write-port next state: load the popped head, otherwise hold address/data.
    always_comb begin
        w_en_d   = pop;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (pop) begin
            w_addr_d = head_rd;
            w_data_d = head_data;
        end
        cnt_d = cnt_q;
        if (w_en_q && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Write-port registers and retired-write counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            cnt_q    <= '0;
        end else begin
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            cnt_q    <= cnt_d;
        end
    end

    // Hazard scoreboard: any live queue entry or the write in flight on w_*.
    always_comb begin
        pend_a = w_en_q && (w_addr_q == i_chk_addrA);
        pend_b = w_en_q && (w_addr_q == i_chk_addrB);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_rd[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == i_chk_addrA)) pend_a = 1'b1;
            if (ent_vld[i] && (ent_rd[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == i_chk_addrB)) pend_b = 1'b1;
        end
        if (rf_is_x0(i_chk_addrA)) pend_a = 1'b0;
        if (rf_is_x0(i_chk_addrB)) pend_b = 1'b0;
    end

    assign o_w_enable = w_en_q;
    assign o_w_addr   = w_addr_q;
    assign o_w_data   = w_data_q;
    assign o_pendA    = pend_a;
    assign o_pendB    = pend_b;
    assign o_idle     = q_empty && !w_en_q;
    assign o_wr_count = cnt_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: directed stimulus, a queue-based reference model
// compared every cycle, and literal expectations for the directed scenarios.
// A second instance with a 4-bit counter shares the stimulus.
module tb_rf_write_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd, chk_a, chk_b;
    logic [31:0] alu_data, lsu_data;

    logic        alu_rdy, lsu_rdy, w_en, pend_a, pend_b, idle;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [15:0] wr_cnt;

    logic        alu_rdy4, lsu_rdy4, w_en4, pend_a4, pend_b4, idle4;
    logic [4:0]  w_addr4;
    logic [31:0] w_data4;
    logic [3:0]  wr_cnt4;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rf_write_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_rdy), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_rdy), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
        .o_w_enable(w_en), .o_w_addr(w_addr), .o_w_data(w_data),
        .i_chk_addrA(chk_a), .i_chk_addrB(chk_b), .o_pendA(pend_a), .o_pendB(pend_b),
        .o_idle(idle), .o_wr_count(wr_cnt)
    );

    rf_write_ctrl #(.CNT_WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_rdy4), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_rdy4), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
        .o_w_enable(w_en4), .o_w_addr(w_addr4), .o_w_data(w_data4),
        .i_chk_addrA(chk_a), .i_chk_addrB(chk_b), .o_pendA(pend_a4), .o_pendB(pend_b4),
        .o_idle(idle4), .o_wr_count(wr_cnt4)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_wen   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int          m_cnt   = 0;
    bit          stall_m = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        int   n;
        bit   l_acc, a_acc;
        if (rst) begin
            mq.delete();
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
        end else begin
            n     = mq.size();
            l_acc = lsu_valid && (n < DEPTH);
            a_acc = alu_valid && (n < DEPTH) && !lsu_valid;
            if (m_wen) m_cnt++;
            if (n > 0 && !stall_m) begin
                e = mq.pop_front();
                m_wen = 1'b1; m_waddr = e.rd; m_wdata = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (l_acc && lsu_rd != 0) begin
                e.rd = lsu_rd; e.data = lsu_data; mq.push_back(e);
            end else if (a_acc && alu_rd != 0) begin
                e.rd = alu_rd; e.data = alu_data; mq.push_back(e);
            end
        end
    end

    function automatic bit m_pend(input logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return m_wen && (m_waddr == a);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int  c16, c4;
        bit  rdy;
        if (chk_en) begin
            c16 = (m_cnt > 65535) ? 65535 : m_cnt;
            c4  = (m_cnt > 15) ? 15 : m_cnt;
            rdy = (mq.size() < DEPTH);
            check("m_w_en",      64'(w_en),    64'(m_wen));
            check("m_w_addr",    64'(w_addr),  64'(m_waddr));
            check("m_w_data",    64'(w_data),  64'(m_wdata));
            check("m_lsu_ready", 64'(lsu_rdy), 64'(rdy));
            check("m_alu_ready", 64'(alu_rdy), 64'(rdy && !lsu_valid));
            check("m_pendA",     64'(pend_a),  64'(m_pend(chk_a)));
            check("m_pendB",     64'(pend_b),  64'(m_pend(chk_b)));
            check("m_idle",      64'(idle),    64'(mq.size() == 0 && !m_wen));
            check("m_wr_count",  64'(wr_cnt),  64'(c16));
            check("m4_w_en",     64'(w_en4),   64'(m_wen));
            check("m4_w_addr",   64'(w_addr4), 64'(m_waddr));
            check("m4_w_data",   64'(w_data4), 64'(m_wdata));
            check("m4_alu_ready",64'(alu_rdy4),64'(rdy && !lsu_valid));
            check("m4_pendA",    64'(pend_a4), 64'(m_pend(chk_a)));
            check("m4_idle",     64'(idle4),   64'(mq.size() == 0 && !m_wen));
            check("m4_wr_count", 64'(wr_cnt4), 64'(c4));
        end
    end

    // Inputs change only 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        chk_a = '0; chk_b = '0;
        tick();
        chk_en = 1'b1;
        tick();
        #3;
        check("rst_idle",      64'(idle),    64'd1);
        check("rst_w_en",      64'(w_en),    64'd0);
        check("rst_wr_count",  64'(wr_cnt),  64'd0);
        check("rst_lsu_ready", 64'(lsu_rdy), 64'd1);

        // Single ALU write to rd=5.
        tick();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #3 check("t1_alu_ready", 64'(alu_rdy), 64'd1);
        tick();                                 // edge 0: accepted
        alu_valid = 1'b0;
        tick();                                 // edge 1
        #3;
        check("t1_w_en",   64'(w_en),   64'd1);
        check("t1_w_addr", 64'(w_addr), 64'd5);
        check("t1_w_data", 64'(w_data), 64'hDEADBEEF);
        tick();                                 // edge 2
        #3;
        check("t1_wr_count", 64'(wr_cnt), 64'd1);
        check("t1_w_en_off", 64'(w_en),   64'd0);

        // ALU and LSU together: LSU wins, ALU follows one cycle later.
        tick();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h0000_0044;
        #3;
        check("t2_lsu_ready", 64'(lsu_rdy), 64'd1);
        check("t2_alu_ready", 64'(alu_rdy), 64'd0);
        tick();                                 // LSU accepted
        lsu_valid = 1'b0;
        #3 check("t2_alu_ready2", 64'(alu_rdy), 64'd1);
        tick();                                 // ALU accepted, rd=4 driven
        alu_valid = 1'b0;
        #3;
        check("t2_first_addr", 64'(w_addr), 64'd4);
        check("t2_first_data", 64'(w_data), 64'h44);
        tick();
        #3;
        check("t2_second_addr", 64'(w_addr), 64'd3);
        check("t2_second_en",   64'(w_en),   64'd1);
        tick();
        tick();

        // ALU write to x0: accepted, never written.
        chk_a = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        #3;
        check("t4_alu_ready", 64'(alu_rdy), 64'd1);
        check("t4_pendA",     64'(pend_a),  64'd0);
        tick();
        alu_valid = 1'b0;
        #3;
        check("t4_idle", 64'(idle), 64'd1);
        tick();
        #3;
        check("t4_w_en",     64'(w_en),   64'd0);
        check("t4_wr_count", 64'(wr_cnt), 64'd3);

        // Fill the queue with draining held off, then reset with 4 queued.
        tick();
        force dut.drain_hold = 1'b1;
        force dut4.drain_hold = 1'b1;
        stall_m = 1'b1;
        chk_a = 5'd1; chk_b = 5'd2;
        for (int i = 0; i < DEPTH; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        alu_rd = 5'd9; alu_data = 32'h9999_9999;
        #3;
        check("t3_full_lsu_ready", 64'(lsu_rdy), 64'd0);
        check("t3_full_alu_ready", 64'(alu_rdy), 64'd0);
        check("t3_full_idle",      64'(idle),    64'd0);
        check("t3_full_pendA",     64'(pend_a),  64'd1);
        tick();
        rst = 1'b1;
        tick();                                 // reset edge with 4 queued
        rst = 1'b0;
        alu_valid = 1'b0;
        release dut.drain_hold;
        release dut4.drain_hold;
        stall_m = 1'b0;
        #3;
        check("t3_idle",     64'(idle),    64'd1);
        check("t3_pendA",    64'(pend_a),  64'd0);
        check("t3_pendB",    64'(pend_b),  64'd0);
        check("t3_w_en",     64'(w_en),    64'd0);
        check("t3_wr_count", 64'(wr_cnt),  64'd0);
        check("t3_wr_cnt4",  64'(wr_cnt4), 64'd0);

        // LSU write to rd=7 tracked by the scoreboard.
        tick();
        chk_a = 5'd7; chk_b = 5'd8;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0077;
        #3 check("t5_pendA_before", 64'(pend_a), 64'd0);
        tick();                                 // accept edge
        lsu_valid = 1'b0;
        #3;
        check("t5_pendA_queued", 64'(pend_a), 64'd1);
        check("t5_pendB",        64'(pend_b), 64'd0);
        tick();
        #3;
        check("t5_pendA_wport", 64'(pend_a), 64'd1);
        check("t5_w_en",        64'(w_en),   64'd1);
        tick();
        #3;
        check("t5_pendA_done", 64'(pend_a), 64'd0);
        check("t5_w_en_done",  64'(w_en),   64'd0);

        // Sustained ALU stream of 20 results.
        tick();
        for (int i = 0; i < 20; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'hA000_0000 + 32'(i);
            #3 check("t6_alu_ready", 64'(alu_rdy), 64'd1);
            tick();
        end
        alu_valid = 1'b0;
        tick();
        tick();
        tick();
        #3;
        check("t6_wr_count",     64'(wr_cnt),  64'd21);
        check("t6_wr_count_sat", 64'(wr_cnt4), 64'd15);
        check("t6_last_addr",    64'(w_addr),  64'd20);
        check("t6_last_data",    64'(w_data),  64'hA000_0013);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
